dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//   Data-side memory stage directly downstream of the single-cycle CPU core.
//   - Consumes the core's daddr/dwdata/dwe and returns drdata in the same cycle.
//   - Decodes two regions: a word-organised data RAM with byte-enabled writes, and
//     a small MMIO page holding a TX byte FIFO, status/flags, a cycle counter and
//     a scratch register.
//   - The TX FIFO drains through a valid/ready byte stream to an external sink.
// PARAMETERS
//   DMEM_WORDS   1024           data RAM depth in 32-bit words (power of two)
//   FIFO_DEPTH   8              TX FIFO depth in bytes (power of two, >=2)
//   MMIO_PAGE    16'hFFFF       daddr[31:16] value selecting the MMIO page
// PORTS
//   clk        in   1   clock; all state updates on rising edge
//   reset      in   1   asynchronous reset, active-low (0 = in reset)
//   daddr      in   32  byte address from core
//   dwdata     in   32  write data from core, lane-replicated by core
//   dwe        in   4   byte write enables; bit i writes dwdata[8i+7:8i]
//   drdata     out  32  read data, combinational from daddr
//   tx_data    out  8   FIFO head byte
//   tx_valid   out  1   FIFO non-empty
//   tx_ready   in   1   sink accepts tx_data when tx_valid & tx_ready
// BEHAVIOUR
//   Decode: mmio = (daddr[31:16] == MMIO_PAGE); otherwise RAM.
//   - RAM index = daddr[$clog2(DMEM_WORDS)+1:2]; upper bits ignored (aliasing).
//   - daddr[1:0] ignored by this block (core already steers lanes via dwe).
//   RAM:
//   - Combinational read of the addressed word.
//   - Synchronous write of each lane whose dwe bit is set.
//   - Contents not reset; RAM is never written while reset is low.
//   MMIO registers, selected by daddr[3:2]; daddr[15:4] ignored:
//   - 0x0 TXDATA (write). A write with dwe[0]=1 pushes dwdata[7:0]. Reads as 0.
//   - 0x4 STATUS (read). Bits:
//       [0]    empty
//       [1]    full
//       [2]    overflow (sticky)
//       [15:8] count, zero-extended
//       all other bits 0
//     A write with any dwe set and dwdata[2]=1 clears overflow.
//   - 0x8 CYCLE (read/write).
//       Free-running 32-bit counter, +1 every cycle, wraps 32'hFFFFFFFF -> 0.
//       A write with dwe=4'b1111 loads dwdata; it then increments from that value
//       on following cycles. A partial-dwe write is ignored and the count continues.
//       A read returns the pre-edge (current) value.
//   - 0xC SCRATCH (read/write). 32-bit register with byte-enabled writes.
//   TX FIFO: circular buffer; rd_ptr/wr_ptr of $clog2(FIFO_DEPTH) bits, wrap
//   naturally; count of $clog2(FIFO_DEPTH)+1 bits.
//   - push = TXDATA write & dwe[0]
//   - pop  = tx_valid & tx_ready
//   - push & !full                -> byte stored at wr_ptr, wr_ptr+1
//   - push & full & !pop          -> byte dropped, overflow <= 1
//   - push & full & pop           -> push accepted, count unchanged, no overflow
//   - push & empty                -> byte visible on tx_data the next cycle
//                                    (no fall-through)
//   - pop                         -> rd_ptr+1
//   - overflow set and clear in the same cycle: set wins.
//   - tx_data = mem[rd_ptr]; holds value when not popped. Undefined when empty;
//     the sink must ignore it.
//   Reset (reset low, asynchronous):
//   - pointers = 0, count = 0, overflow = 0, CYCLE = 0, SCRATCH = 0
//   - tx_valid = 0; drdata follows decode of RAM/regs
//   - Deassertion is synchronised by the core's reset sequencing; state resumes on
//     the first rising edge with reset high.
//   - Reset mid-stream: FIFO contents discarded; tx_valid drops immediately,
//     without waiting for clk.
// TESTING
//   1. RAM byte lanes: SW 0x11223344 to 0x40, then SB 0xAA with dwe=0100 to 0x42.
//      -> read 0x40 = 0x11AA3344; read 0x1040 with DMEM_WORDS=1024 aliases to the
//      same word.
//   2. FIFO fill/overflow: tx_ready=0; push 9 bytes 0x01..0x09.
//      -> STATUS = 0x0000_0806 (count 8, full, overflow); tx_data = 0x01.
//      Write STATUS with dwdata=0x4 -> overflow clears.
//   3. Full + simultaneous push/pop: FIFO full, tx_ready=1 and push 0x55 in the
//      same cycle -> count stays 8, overflow 0; 0x55 emerges after 7 further pops.
//   4. CYCLE: after reset release, read over 10 cycles -> strictly +1 per cycle.
//      - Write 0xFFFFFFFE, dwe=1111 -> next reads 0xFFFFFFFE, 0xFFFFFFFF,
//        0x00000000.
//      - Write with dwe=0011 -> ignored.
//   5. Async reset mid-drain: 3 bytes queued, pull reset low between edges
//      -> tx_valid=0 and STATUS=0x1 before the next clk edge; CYCLE and SCRATCH
//      read 0.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory stage behind the single-cycle core.
// Word-organised data RAM with byte-enabled writes, plus an MMIO page holding
// a TX byte FIFO, a status word, a free-running cycle counter and a scratch
// register. All reads are combinational from daddr.
//
// TX stream handshake: tx_valid is high whenever the FIFO holds a byte and
// tx_data is the head byte. A byte transfers on a rising edge where
// tx_valid & tx_ready are both high. tx_data holds while not popped and is
// meaningless when tx_valid is low.
module dmem_mmio #(
   parameter int unsigned DMEM_WORDS = 1024,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int AW = $clog2(DMEM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CYCLE   = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

   logic          mmio;
   logic [1:0]    reg_sel;
   logic [AW-1:0] ram_idx;

   logic [31:0]   ram [DMEM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [31:0]   cycle_cnt;
   logic [31:0]   scratch;

   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          push_ok;
   logic          ovf_set;
   logic          ovf_clr;
   logic          cycle_load;
   logic [7:0]    status_count;
   logic          unused_addr;

   // Address decode: upper half selects the MMIO page, low bits pick a word.
   assign mmio    = (daddr[31:16] == MMIO_PAGE);
   assign reg_sel = daddr[3:2];
   assign ram_idx = daddr[AW+1:2];

   // Byte-lane steering is done by the core, so daddr[1:0] carries nothing here.
   assign unused_addr = ^{daddr[15:4], daddr[1:0]};

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign tx_valid = !empty;
   assign tx_data  = fifo_mem[rd_ptr];

   assign pop        = tx_valid & tx_ready;
   assign push       = mmio && (reg_sel == REG_TXDATA) && dwe[0];
   // A push into a full FIFO still succeeds if a byte leaves in the same cycle.
   assign push_ok    = push && (!full || pop);
   assign ovf_set    = push && full && !pop;
   assign ovf_clr    = mmio && (reg_sel == REG_STATUS) && (|dwe) && dwdata[2];
   assign cycle_load = mmio && (reg_sel == REG_CYCLE) && (dwe == 4'b1111);

   assign status_count = 8'(count);

   // Data RAM: per-lane synchronous write, suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (reset && !mmio) begin
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   // FIFO storage: written only when a push is accepted.
   always_ff @(posedge clk) begin
      if (reset && push_ok) fifo_mem[wr_ptr] <= dwdata[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag (set beats clear).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // Cycle counter: full-word write loads, otherwise counts every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          cycle_cnt <= '0;
      else if (cycle_load) cycle_cnt <= dwdata;
      else                 cycle_cnt <= cycle_cnt + 32'd1;
   end

   // Scratch register with byte-enabled writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scratch <= '0;
      end else if (mmio && (reg_sel == REG_SCRATCH)) begin
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) scratch[8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   // Read mux: RAM word or MMIO register, purely from the current address.
   always_comb begin
      drdata = '0;
      if (mmio) begin
         case (reg_sel)
            REG_STATUS:  drdata = {16'h0, status_count, 5'b0, overflow, full, empty};
            REG_CYCLE:   drdata = cycle_cnt;
            REG_SCRATCH: drdata = scratch;
            default:     drdata = '0;
         endcase
      end else begin
         drdata = ram[ram_idx];
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: RAM lanes and aliasing, MMIO registers,
// TX FIFO fill/overflow/drain, randomized streaming and asynchronous reset.
module tb_dmem_mmio;

  localparam logic [31:0] A_TX = 32'hFFFF_0000;
  localparam logic [31:0] A_ST = 32'hFFFF_0004;
  localparam logic [31:0] A_CY = 32'hFFFF_0008;
  localparam logic [31:0] A_SC = 32'hFFFF_000C;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int errors;
  int checks;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  dmem_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // driver tasks
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    daddr  = a;
    dwdata = d;
    dwe    = be;
    @(posedge clk);
    #1;
    dwe = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge clk);
    daddr = a;
    dwe   = 4'b0000;
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    daddr    = 32'h0;
    dwdata   = 32'h0;
    dwe      = 4'b0000;
    tx_ready = 1'b0;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rd(A_ST);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_valid got=%b exp=0", tx_valid);
    end
    exp = exp_q.pop_front();
    checks++;
    if (drdata !== exp) begin
      errors++;
      $display("FAIL reset_status got=%h exp=%h", drdata, exp);
    end
    rd(A_CY);
    exp = exp_q.pop_front();
    checks++;
    if (drdata !== exp) begin
      errors++;
      $display("FAIL reset_cycle got=%h exp=%h", drdata, exp);
    end
    rd(A_SC);
    exp = exp_q.pop_front();
    checks++;
    if (drdata !== exp) begin
      errors++;
      $display("FAIL reset_scratch got=%h exp=%h", drdata, exp);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_cycle();
    logic [31:0] ld;
    @(negedge clk);
    reset = 1'b0;
    daddr = A_CY;
    @(negedge clk);
    reset = 1'b1;
    #1;
    // first read before any edge with reset high, then +1 per cycle
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      exp_q.push_back(32'(i));
      exp = exp_q.pop_front();
      checks++;
      if (drdata !== exp) begin
        errors++;
        $display("FAIL cycle_count i=%0d got=%h exp=%h", i, drdata, exp);
      end
    end
    ld = 32'hFFFF_FFFE;
    wr(A_CY, ld, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      exp_q.push_back(ld + 32'(i));
      exp = exp_q.pop_front();
      checks++;
      if (drdata !== exp) begin
        errors++;
        $display("FAIL cycle_wrap i=%0d got=%h exp=%h", i, drdata, exp);
      end
    end
    // partial write: value shown is 1 and it must keep counting to 2
    @(negedge clk);
    dwdata = 32'h0;
    dwe    = 4'b0011;
    #1;
    checks++;
    if (drdata !== 32'h1) begin
      errors++;
      $display("FAIL cycle_partial_pre got=%h exp=%h", drdata, 32'h1);
    end
    @(posedge clk);
    #1;
    dwe = 4'b0000;
    @(negedge clk);
    #1;
    checks++;
    if (drdata !== 32'h2) begin
      errors++;
      $display("FAIL cycle_partial_ignored got=%h exp=%h", drdata, 32'h2);
    end
  endtask

  task automatic test_ram();
    logic [31:0] a;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  be;
    logic [31:0] m;
    wr(32'h40, 32'h1122_3344, 4'b1111);
    wr(32'h42, 32'hAAAA_AAAA, 4'b0100);
    exp_q.push_back(32'h11AA_3344);
    exp_q.push_back(32'h11AA_3344);
    rd(32'h40);
    exp = exp_q.pop_front();
    checks++;
    if (drdata !== exp) begin
      errors++;
      $display("FAIL ram_lane got=%h exp=%h", drdata, exp);
    end
    rd(32'h1040);
    exp = exp_q.pop_front();
    checks++;
    if (drdata !== exp) begin
      errors++;
      $display("FAIL ram_alias got=%h exp=%h", drdata, exp);
    end
    for (int i = 0; i < 4; i++) begin
      a  = 32'h200 + 32'(4 * i);
      d0 = $urandom;
      d1 = $urandom;
      be = 4'($urandom_range(1, 14));
      wr(a, d0, 4'b1111);
      wr(a, d1, be);
      for (int k = 0; k < 4; k++) m[8*k +: 8] = be[k] ? d1[8*k +: 8] : d0[8*k +: 8];
      exp_q.push_back(m);
    end
    for (int i = 0; i < 4; i++) begin
      rd(32'h200 + 32'(4 * i));
      exp = exp_q.pop_front();
      checks++;
      if (drdata !== exp) begin
        errors++;
        $display("FAIL ram_random i=%0d got=%h exp=%h", i, drdata, exp);
      end
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] m;
    d0 = 32'hDEAD_BEEF;
    d1 = 32'h1234_5678;
    wr(A_SC, d0, 4'b1111);
    wr(A_SC, d1, 4'b1010);
    for (int k = 0; k < 4; k++) m[8*k +: 8] = (k % 2 == 1) ? d1[8*k +: 8] : d0[8*k +: 8];
    exp_q.push_back(m);
    rd(A_SC);
    exp = exp_q.pop_front();
    checks++;
    if (drdata !== exp) begin
      errors++;
      $display("FAIL scratch_bytes got=%h exp=%h", drdata, exp);
    end
    rd(A_TX);
    checks++;
    if (drdata !== 32'h0) begin
      errors++;
      $display("FAIL txdata_reads_zero got=%h exp=%h", drdata, 32'h0);
    end
  endtask

  task automatic test_fifo_fill();
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      wr(A_TX, {4{8'(i)}}, 4'b0001);
      if (exp_q.size() < 8) exp_q.push_back(32'(i));
    end
    rd(A_ST);
    checks++;
    if (drdata !== 32'h0000_0806) begin
      errors++;
      $display("FAIL fifo_full_status got=%h exp=%h", drdata, 32'h0000_0806);
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[0][7:0]) begin
      errors++;
      $display("FAIL fifo_head got=%b/%h exp=1/%h", tx_valid, tx_data, exp_q[0][7:0]);
    end
    wr(A_ST, 32'h4, 4'b1111);
    rd(A_ST);
    checks++;
    if (drdata !== 32'h0000_0802) begin
      errors++;
      $display("FAIL ovf_clear got=%h exp=%h", drdata, 32'h0000_0802);
    end
  endtask

  task automatic test_full_push_pop();
    @(negedge clk);
    daddr    = A_TX;
    dwdata   = 32'h5555_5555;
    dwe      = 4'b0001;
    tx_ready = 1'b1;
    #1;
    exp = exp_q.pop_front();
    exp_q.push_back(32'h55);
    checks++;
    if (tx_data !== exp[7:0]) begin
      errors++;
      $display("FAIL full_pushpop_head got=%h exp=%h", tx_data, exp[7:0]);
    end
    @(posedge clk);
    #1;
    dwe      = 4'b0000;
    tx_ready = 1'b0;
    rd(A_ST);
    checks++;
    if (drdata !== 32'h0000_0802) begin
      errors++;
      $display("FAIL full_pushpop_status got=%h exp=%h", drdata, 32'h0000_0802);
    end
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[7:0]) begin
        errors++;
        $display("FAIL drain_byte got=%b/%h exp=1/%h", tx_valid, tx_data, exp[7:0]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d left exp=0", exp_q.size());
    end
    rd(A_ST);
    tx_ready = 1'b0;
    checks++;
    if (drdata !== 32'h1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got=%h/%b exp=%h/0", drdata, tx_valid, 32'h1);
    end
  endtask

  task automatic test_back_to_back();
    logic       p;
    logic       r;
    logic [7:0] b;
    logic       ovf_m;
    ovf_m = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      p = 1'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 255));
      r = (n < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      daddr    = A_TX;
      dwdata   = {4{b}};
      dwe      = p ? 4'b0001 : 4'b0000;
      tx_ready = r;
      #1;
      checks++;
      if (tx_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL b2b_valid n=%0d got=%b exp=%b", n, tx_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0 && r) begin
        exp = exp_q.pop_front();
        checks++;
        if (tx_data !== exp[7:0]) begin
          errors++;
          $display("FAIL b2b_data n=%0d got=%h exp=%h", n, tx_data, exp[7:0]);
        end
      end
      if (p) begin
        if (exp_q.size() < 8) exp_q.push_back(32'(b));
        else ovf_m = 1'b1;
      end
    end
    @(negedge clk);
    dwe = 4'b0000;
    tx_ready = 1'b0;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[7:0]) begin
        errors++;
        $display("FAIL b2b_drain got=%b/%h exp=1/%h", tx_valid, tx_data, exp[7:0]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain_timeout got=%0d left exp=0", exp_q.size());
    end
    rd(A_ST);
    tx_ready = 1'b0;
    exp = ovf_m ? 32'h5 : 32'h1;
    checks++;
    if (drdata !== exp) begin
      errors++;
      $display("FAIL b2b_status got=%h exp=%h", drdata, exp);
    end
    wr(A_ST, 32'h4, 4'b0001);
  endtask

  task automatic test_async_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_TX, {4{8'(8'hA0 + i)}}, 4'b0001);
    wr(A_SC, 32'hCAFE_F00D, 4'b1111);
    @(negedge clk);
    daddr = A_ST;
    #1;
    checks++;
    if (tx_valid !== 1'b1 || drdata !== 32'h0000_0300) begin
      errors++;
      $display("FAIL pre_reset got=%b/%h exp=1/%h", tx_valid, drdata, 32'h0000_0300);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_tx_valid got=%b exp=0", tx_valid);
    end
    checks++;
    if (drdata !== 32'h1) begin
      errors++;
      $display("FAIL async_status got=%h exp=%h", drdata, 32'h1);
    end
    daddr = A_CY;
    #1;
    checks++;
    if (drdata !== 32'h0) begin
      errors++;
      $display("FAIL async_cycle got=%h exp=%h", drdata, 32'h0);
    end
    daddr = A_SC;
    #1;
    checks++;
    if (drdata !== 32'h0) begin
      errors++;
      $display("FAIL async_scratch got=%h exp=%h", drdata, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    rd(A_ST);
    checks++;
    if (tx_valid !== 1'b0 || drdata !== 32'h1) begin
      errors++;
      $display("FAIL post_reset got=%b/%h exp=0/%h", tx_valid, drdata, 32'h1);
    end
  endtask

  // test sequence and final report
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_cycle();
    test_ram();
    test_scratch();
    test_fifo_fill();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
